// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, LSB-first data, optional parity, stop bits.
// A single holding buffer lets the next word queue behind the frame on the line.
module piso_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 send_valid,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 send_ready,
  output logic                 data_tx,
  output logic                 active_flag,
  output logic                 sent_flag
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic [4:0] LAST_STOP = 5'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 parity_bit;
  logic [4:0]           bit_cnt;

  assign send_ready = !hold_full && !reset;

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_full   <= 1'b0;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      sent_flag   <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      sent_flag <= 1'b0;

      // The buffer only fills mid-frame; a word offered at the final stop edge goes straight to the shifter.
      if (state != IDLE && send_valid && !hold_full &&
          !(state == STOP && bit_cnt == LAST_STOP)) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (send_valid && !hold_full) begin
            shift_reg   <= data_in;
            parity_bit  <= (^data_in) ^ ODD;
            state       <= START;
            data_tx     <= 1'b0;
            active_flag <= 1'b1;
          end
        end
        START: begin
          data_tx   <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
          state     <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
            if (PARITY_EN != 0) begin
              state   <= PARITY;
              data_tx <= parity_bit;
            end else begin
              state   <= STOP;
              data_tx <= 1'b1;
            end
          end else begin
            data_tx   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 5'd1;
          end
        end
        PARITY: begin
          state   <= STOP;
          data_tx <= 1'b1;
          bit_cnt <= '0;
        end
        STOP: begin
          if (bit_cnt == LAST_STOP) begin
            sent_flag <= 1'b1;
            bit_cnt   <= '0;
            if (hold_full) begin
              shift_reg  <= hold_data;
              parity_bit <= (^hold_data) ^ ODD;
              hold_full  <= 1'b0;
              state      <= START;
              data_tx    <= 1'b0;
            end else if (send_valid) begin
              shift_reg  <= data_in;
              parity_bit <= (^data_in) ^ ODD;
              state      <= START;
              data_tx    <= 1'b0;
            end else begin
              state       <= IDLE;
              data_tx     <= 1'b1;
              active_flag <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            data_tx <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          data_tx     <= 1'b1;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: default, odd-parity and 7-bit/no-parity/2-stop instances
// share one stimulus stream; each test checks the instance it targets.
module tb_piso_tx;

  logic       baud_clk;
  logic       reset;
  logic       send_valid;
  logic [7:0] data_in;
  logic [2:0] rdy, tx, act, sent;

  int testsRun    = 0;
  int testsFailed = 0;

  piso_tx dut0 (
    .baud_clk(baud_clk), .reset(reset), .send_valid(send_valid), .data_in(data_in),
    .send_ready(rdy[0]), .data_tx(tx[0]), .active_flag(act[0]), .sent_flag(sent[0])
  );

  piso_tx #(.PARITY_ODD(1)) dut1 (
    .baud_clk(baud_clk), .reset(reset), .send_valid(send_valid), .data_in(data_in),
    .send_ready(rdy[1]), .data_tx(tx[1]), .active_flag(act[1]), .sent_flag(sent[1])
  );

  piso_tx #(.DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .baud_clk(baud_clk), .reset(reset), .send_valid(send_valid), .data_in(data_in[6:0]),
    .send_ready(rdy[2]), .data_tx(tx[2]), .active_flag(act[2]), .sent_flag(sent[2])
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    send_valid = valid;
    data_in    = data;
    tick();
  endtask

  task automatic doReset();
    reset      = 1'b1;
    send_valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_ready", 32'(rdy[0]), 32'd0);
    checkOutput("rst_tx", 32'(tx[0]), 32'd1);
    checkOutput("rst_active", 32'(act[0]), 32'd0);
    checkOutput("rst_sent", 32'(sent[0]), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(rdy[0]), 32'd1);
    checkOutput("post_rst_active", 32'(act[0]), 32'd0);
  endtask

  // Walks one frame starting in its start-bit cycle, then checks the end-of-frame pulse.
  task automatic checkFrame(input int sel, input string exp, input string tag);
    for (int i = 0; i < exp.len(); i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), 32'(tx[sel]), 32'(exp[i] == "1"));
      checkOutput($sformatf("%s_act%0d", tag, i), 32'(act[sel]), 32'd1);
      tick();
    end
    checkOutput($sformatf("%s_sent", tag), 32'(sent[sel]), 32'd1);
    checkOutput($sformatf("%s_idle_tx", tag), 32'(tx[sel]), 32'd1);
    checkOutput($sformatf("%s_idle_act", tag), 32'(act[sel]), 32'd0);
    tick();
    checkOutput($sformatf("%s_sent_clr", tag), 32'(sent[sel]), 32'd0);
    checkOutput($sformatf("%s_idle_tx2", tag), 32'(tx[sel]), 32'd1);
  endtask

  // 0x3C on the line, 0xC3 buffered behind it, optionally 0xFF held against a full buffer.
  task automatic runChain(input string exp, input bit withFf);
    logic expReady;
    logic expSent;
    for (int i = 0; i < exp.len(); i++) begin
      if (i == 0)                 expReady = 1'b1;
      else if (i <= 10)           expReady = 1'b0;
      else if (i == 11)           expReady = 1'b1;
      else if (withFf && i <= 21) expReady = 1'b0;
      else                        expReady = 1'b1;
      expSent = (i == 11) || (withFf && i == 22);
      checkOutput($sformatf("chain_bit%0d", i), 32'(tx[0]), 32'(exp[i] == "1"));
      checkOutput($sformatf("chain_act%0d", i), 32'(act[0]), 32'd1);
      checkOutput($sformatf("chain_sent%0d", i), 32'(sent[0]), 32'(expSent));
      checkOutput($sformatf("chain_ready%0d", i), 32'(rdy[0]), 32'(expReady));
      if (i == 0) data_in = 8'hC3;
      if (i == 1) begin
        if (withFf) data_in = 8'hFF;
        else        send_valid = 1'b0;
      end
      if (withFf && i == 12) send_valid = 1'b0;
      tick();
    end
    checkOutput("chain_end_sent", 32'(sent[0]), 32'd1);
    checkOutput("chain_end_act", 32'(act[0]), 32'd0);
    checkOutput("chain_end_tx", 32'(tx[0]), 32'd1);
    tick();
    checkOutput("chain_end_sent_clr", 32'(sent[0]), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    send_valid = 1'b0;
    data_in    = 8'h00;
    doReset();

    // Single default frame; data_in changes right after capture.
    applyStimulus(1'b1, 8'hA5);
    send_valid = 1'b0;
    data_in    = 8'h00;
    checkFrame(0, "01010010101", "a5");

    applyStimulus(1'b1, 8'h01);
    send_valid = 1'b0;
    checkFrame(1, "01000000001", "odd01");
    applyStimulus(1'b1, 8'h00);
    send_valid = 1'b0;
    checkFrame(1, "00000000011", "odd00");

    applyStimulus(1'b1, 8'h55);
    send_valid = 1'b0;
    checkFrame(2, "0101010111", "np55");

    doReset();
    applyStimulus(1'b1, 8'h3C);
    runChain("0001111000101100001101", 1'b0);

    doReset();
    applyStimulus(1'b1, 8'h3C);
    runChain("000111100010110000110101111111101", 1'b1);

    // Word offered on the final stop bit with the buffer empty starts immediately.
    doReset();
    applyStimulus(1'b1, 8'h3C);
    send_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("direct_stop_tx", 32'(tx[0]), 32'd1);
    applyStimulus(1'b1, 8'h81);
    send_valid = 1'b0;
    checkOutput("direct_sent", 32'(sent[0]), 32'd1);
    checkOutput("direct_ready", 32'(rdy[0]), 32'd1);
    checkFrame(0, "01000000101", "direct81");

    // Reset during data bit 4 with 0xC3 buffered.
    doReset();
    applyStimulus(1'b1, 8'h3C);
    data_in = 8'hC3;
    tick();
    send_valid = 1'b0;
    checkOutput("midrst_buffered_ready", 32'(rdy[0]), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_bit4", 32'(tx[0]), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_tx", 32'(tx[0]), 32'd1);
    checkOutput("midrst_active", 32'(act[0]), 32'd0);
    checkOutput("midrst_sent", 32'(sent[0]), 32'd0);
    checkOutput("midrst_ready_in_rst", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ready_after", 32'(rdy[0]), 32'd1);
    for (int i = 0; i < 25; i++) begin
      tick();
      checkOutput($sformatf("midrst_quiet_tx%0d", i), 32'(tx[0]), 32'd1);
      checkOutput($sformatf("midrst_quiet_sent%0d", i), 32'(sent[0]), 32'd0);
      checkOutput($sformatf("midrst_quiet_act%0d", i), 32'(act[0]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of payload bits per frame (1..16).
REQ-002 Parameter PARITY_EN, default 1, 1 = parity bit inserted after data, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 baud_clk  input  1  bit clock; one frame bit per cycle; sole clock.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising baud_clk.
REQ-007 send_valid  input  1  data_in holds a word to transmit.
REQ-008 data_in  input  DATA_BITS  payload word, transmitted LSB first.
REQ-009 send_ready  output  1  block can accept a word this cycle.
REQ-010 data_tx  output  1  registered serial line, idle high.
REQ-011 active_flag  output  1  high while a frame is being driven on data_tx.
REQ-012 sent_flag  output  1  one-cycle pulse after the final stop bit of each frame.

Function
REQ-013 FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS; each frame drives data_tx for exactly FRAME_W cycles.
REQ-014 Frame order: start bit 0, data_in[0]..data_in[DATA_BITS-1], parity bit (if enabled), STOP_BITS stop bits of 1.
REQ-015 Parity bit = XOR of the data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-017 Transfer occurs on a rising edge where send_valid and send_ready are both 1; data_in is captured at that edge.
REQ-018 Block contains one shift register and one holding buffer; send_ready = 1 exactly when the holding buffer is empty and reset is low.
REQ-019 Transfer in IDLE with buffer empty: word goes directly to the shift register, FSM enters START, and data_tx = 0 in the cycle following that edge.
REQ-020 Transfer while active_flag = 1: word is stored in the holding buffer and send_ready falls in the next cycle.
REQ-021 Transitions: START -> DATA after 1 cycle, DATA -> PARITY (or STOP) after DATA_BITS cycles, PARITY -> STOP after 1 cycle, STOP -> IDLE after STOP_BITS cycles.
REQ-022 At the edge ending the last stop bit, a full buffer is moved into the shift register: FSM enters START with no idle cycle, the buffer clears, and send_ready rises.
REQ-023 At the edge ending the last stop bit with the buffer empty, a simultaneous transfer also goes straight to START (back-to-back); otherwise FSM enters IDLE and data_tx = 1.
REQ-024 sent_flag is high for exactly the one cycle following the edge that ends each frame's last stop bit, including back-to-back frames.
REQ-025 active_flag is high in START, DATA, PARITY and STOP, stays high across back-to-back frames, and is low in IDLE.
REQ-026 A change of data_in after its transfer edge has no effect on the frame in progress or on the buffered word.

Reset
REQ-027 While reset = 1 at a rising edge: FSM -> IDLE, buffer -> empty, data_tx = 1, active_flag = 0, sent_flag = 0, send_ready = 0.
REQ-028 Reset asserted mid-frame aborts the frame and discards the buffered word; data_tx = 1 in the cycle after the reset edge, and no sent_flag pulse is produced.
REQ-029 In the first cycle after reset deasserts: send_ready = 1 and FSM is IDLE.

Verification
REQ-030 Single frame (defaults): send 0xA5 -> data_tx over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; sent_flag pulses once, then data_tx stays 1.
REQ-031 Odd parity (PARITY_ODD=1): send 0x01 -> parity bit = 0; send 0x00 -> parity bit = 1.
REQ-032 Back-to-back: send 0x3C, then hold send_valid with 0xC3 -> second start bit immediately follows the first stop bit; active_flag stays high for 22 cycles; sent_flag pulses twice.
REQ-033 Backpressure: with buffer full, send_ready = 0 and a held send_valid with 0xFF is not accepted until the edge ending the current frame.
REQ-034 Config PARITY_EN=0, STOP_BITS=2, DATA_BITS=7: send 0x55 -> 10-cycle frame 0,1,0,1,0,1,0,1,1,1.
REQ-035 Reset during DATA bit 4 with a word buffered -> data_tx = 1 and active_flag = 0 next cycle, no sent_flag pulse, send_ready = 1 after reset deasserts, and no residual frame is transmitted.
